// File: rtl/knn_pkg.sv
// Shared kNN types and constants used by the frame packer and the sorter.
package knn_pkg;

  localparam int unsigned KNN_N = 17;
  localparam int unsigned KNN_W = 32;
  localparam int unsigned CNT_W = 5;

  typedef logic [KNN_W-1:0] dist_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam dist_t DIST_PAD = {KNN_W{1'b1}};

endpackage

// File: rtl/knn_frame_bank.sv
// One ping-pong frame bank: word storage, count, last and full flags,
// and a read port that masks slots at or beyond count to PAD.
module knn_frame_bank
  import knn_pkg::*;
#(
  parameter int unsigned N   = KNN_N,
  parameter int unsigned W   = KNN_W,
  parameter logic [W-1:0] PAD = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [4:0]   wr_idx,
  input  logic [W-1:0] wr_data,
  input  logic         close,
  input  logic [4:0]   close_count,
  input  logic         close_last,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] rd_data [N],
  output logic [4:0]   rd_count,
  output logic         rd_last
);

  logic [W-1:0] mem [N];
  cnt_t         count;
  logic         last;

  // Storage is not reset; the count mask hides stale words.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      count <= '0;
      last  <= 1'b0;
    end else begin
      if (clr) begin
        full <= 1'b0;
      end else if (close) begin
        full <= 1'b1;
      end
      if (close) begin
        count <= close_count;
        last  <= close_last;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      rd_data[i] = (cnt_t'(i) < count) ? mem[i] : PAD;
    end
  end

  assign rd_count = count;
  assign rd_last  = last;

endmodule

// File: rtl/knn_frame_packer.sv
// Packs a valid/ready distance stream into N-entry frames using two
// ping-pong banks and presents each full frame in parallel to the sorter.
module knn_frame_packer
  import knn_pkg::*;
#(
  parameter int unsigned N   = KNN_N,
  parameter int unsigned W   = KNN_W,
  parameter logic [W-1:0] PAD = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [W-1:0] frame_data [N],
  output logic [4:0]   frame_count,
  output logic         frame_last
);

  cnt_t         fill;
  logic         wb;
  logic         rb;
  logic [1:0]   full;
  logic [1:0]   bank_last;
  logic [4:0]   bank_count [2];
  logic [W-1:0] bank_data  [2][N];
  logic         accept;
  logic         close;
  logic         drain;
  cnt_t         fill_inc;

  // Ready depends only on registered bank state, never on frame_ready.
  assign in_ready    = ~full[wb];
  assign accept      = in_valid & in_ready;
  assign fill_inc    = fill + cnt_t'(1);
  assign close       = accept & (in_last | (fill == cnt_t'(N - 1)));
  assign frame_valid = full[rb];
  assign drain       = frame_valid & frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
    end else begin
      if (accept) begin
        fill <= close ? '0 : fill_inc;
      end
      if (close) begin
        wb <= ~wb;
      end
      if (drain) begin
        rb <= ~rb;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    knn_frame_bank #(
      .N  (N),
      .W  (W),
      .PAD(PAD)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (accept && (wb == 1'(b))),
      .wr_idx     (fill),
      .wr_data    (in_data),
      .close      (close && (wb == 1'(b))),
      .close_count(fill_inc),
      .close_last (in_last),
      .clr        (drain && (rb == 1'(b))),
      .full       (full[b]),
      .rd_data    (bank_data[b]),
      .rd_count   (bank_count[b]),
      .rd_last    (bank_last[b])
    );
  end

  // Sorter side always looks at the read bank.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      frame_data[i] = bank_data[rb][i];
    end
  end

  assign frame_count = bank_count[rb];
  assign frame_last  = bank_last[rb];

endmodule
